// File: rtl/tinker_fetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches under a credit limit,
// buffers in-order responses with their PCs for decode, and flushes on redirect.
module tinker_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h2000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  // Stale requests left behind by back-to-back redirects can push the in-flight total past DEPTH.
  localparam int OW = CW + 4;

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   resp_pc_reg, resp_pc_next;
  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic [OW-1:0] outstanding_reg, outstanding_next;
  logic [OW-1:0] drop_reg, drop_next;
  logic          run_reg;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic [OW:0] credit_used;
  logic        credit_ok;
  logic        req_fire;
  logic        resp_keep;
  logic        pop;
  logic [31:0] redirect_base;
  logic        unused_redirect_low;

  assign redirect_base       = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_low = ^redirect_pc[1:0];

  // Words already marked for discard do not occupy a FIFO slot when they land.
  assign credit_used = (OW+1)'(count_reg) + (OW+1)'(outstanding_reg) - (OW+1)'(drop_reg);
  assign credit_ok   = (credit_used < (OW+1)'(DEPTH)) && (outstanding_reg != '1);

  assign mem_req_valid = run_reg & ~redirect_valid & credit_ok;
  assign mem_req_addr  = fetch_pc_reg;

  assign dec_valid = (count_reg != '0) & ~redirect_valid;
  assign dec_instr = dec_valid ? instr_mem[head_reg] : 32'h0;
  assign dec_pc    = dec_valid ? pc_mem[head_reg] : 32'h0;

  assign req_fire  = mem_req_valid & mem_req_ready;
  assign resp_keep = mem_resp_valid & (drop_reg == '0) & ~redirect_valid;
  assign pop       = dec_valid & dec_ready;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    head_next        = head_reg;
    tail_next        = tail_reg;
    count_next       = count_reg;
    outstanding_next = outstanding_reg + OW'(req_fire) - OW'(mem_resp_valid);
    drop_next        = drop_reg;
    if (redirect_valid) begin
      fetch_pc_next = redirect_base;
      resp_pc_next  = redirect_base;
      head_next     = '0;
      tail_next     = '0;
      count_next    = '0;
      // Everything still in flight belongs to the old path, including a word landing now.
      drop_next     = outstanding_reg - OW'(mem_resp_valid);
    end else begin
      if (req_fire)
        fetch_pc_next = fetch_pc_reg + 32'd4;
      if (mem_resp_valid && (drop_reg != '0))
        drop_next = drop_reg - OW'(1);
      if (resp_keep) begin
        resp_pc_next = resp_pc_reg + 32'd4;
        tail_next    = tail_reg + PW'(1);
      end
      if (pop)
        head_next = head_reg + PW'(1);
      count_next = count_reg + CW'(resp_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      run_reg         <= 1'b0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      head_reg        <= head_next;
      tail_reg        <= tail_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      run_reg         <= 1'b1;
    end
  end

  // Entry storage needs no reset: outputs are gated by dec_valid.
  always_ff @(posedge clk) begin
    if (resp_keep) begin
      pc_mem[tail_reg]    <= resp_pc_reg;
      instr_mem[tail_reg] <= mem_resp_data;
    end
  end

endmodule
